inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch stage that feeds the single-cycle core's 32-bit instruction input (cmd).
//   Owns the fetch PC and issues one request at a time to instruction memory over a valid/ready request channel.
//   Captures the memory response and presents instruction + PC to the core with a valid/ready handshake.
//   Accepts PC redirects from the core's branch/jump logic and squashes any stale in-flight fetch.
// PARAMETERS
//   RESET_PC   32'h8000_0000   fetch PC loaded on reset
//   XLEN       32              address/instruction width; only 32 is supported
// PORTS
//   clk              in   1     clock, all state updates on rising edge
//   rst              in   1     asynchronous, active-low reset (0 = in reset)
//   imem_req_valid   out  1     fetch request valid
//   imem_req_ready   in   1     memory accepts request this cycle
//   imem_req_addr    out  32    fetch address (= pc)
//   imem_resp_valid  in   1     response data valid (1-cycle pulse)
//   imem_resp_data   in   32    fetched instruction word
//   inst_valid       out  1     inst/inst_pc valid toward core
//   inst_ready       in   1     core consumes instruction this cycle
//   inst             out  32    instruction to core (cmd)
//   inst_pc          out  32    PC of inst
//   redirect_valid   in   1     core requests PC change
//   redirect_pc      in   32    new fetch PC
//   fetch_fault      out  1     misaligned-fetch fault (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0): state=IDLE, pc=RESET_PC, drop=0, inst=0, inst_pc=0, outputs valid/fault=0.
//   States: IDLE, REQ, WAIT, HOLD. imem_req_valid=(state==REQ); inst_valid=(state==HOLD).
//   IDLE: -> REQ next cycle unconditionally.
//   REQ:  imem_req_addr=pc. On imem_req_ready -> WAIT. Addr stays stable while unaccepted, except on redirect.
//   WAIT: on imem_resp_valid: if drop, clear drop, -> REQ (data discarded);
//         else inst<=resp_data, inst_pc<=pc, -> HOLD.
//   HOLD: inst/inst_pc held stable. On inst_ready: pc<=pc+4, -> REQ.
//   Redirect (redirect_valid=1), highest priority over pc+4:
//     REQ, no handshake: pc<=redirect_pc, stay REQ.
//     REQ with handshake same cycle: pc<=redirect_pc, drop<=1, -> WAIT.
//     WAIT, no response: pc<=redirect_pc, drop<=1, stay WAIT.
//     WAIT with response same cycle: pc<=redirect_pc, discard data, drop<=0, -> REQ.
//     HOLD (with or without inst_ready): instruction treated as consumed, pc<=redirect_pc, -> REQ.
//     IDLE: pc<=redirect_pc.
//   imem_resp_valid outside WAIT is ignored.
//   At most one request outstanding. drop ensures exactly one response is discarded per squashed fetch.
//   pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
//   Latency: zero-wait memory (ready=1, resp the cycle after accept) -> inst_valid 2 cycles after REQ entry.
//   Best throughput: 1 inst / 3 cycles.
//   Reset asserted mid-fetch: immediate return to reset state. A response arriving afterward is ignored (state != WAIT).
// CONFIGURATION
//   IFU_MISALIGN_TRAP_EN defined:
//     - A redirect with redirect_pc[1:0]!=0 loads pc and enters HOLD directly, with no memory request.
//     - In that HOLD: fetch_fault=1, inst=32'h0000_0000, inst_pc=redirect_pc.
//     - Cleared by the next redirect, or by inst_ready (pc<=pc+4, -> REQ).
//   Not defined:
//     - fetch_fault tied to 0.
//     - redirect_pc[1:0] is ignored; pc loads {redirect_pc[31:2],2'b00}.
// TESTING
//   Reset release, ready=1, 1-cycle mem -> first req addr 0x8000_0000; inst_valid at cycle 3 with inst_pc 0x8000_0000.
//   inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new request; ready=1 -> next addr 0x8000_0004.
//   Redirect to 0x8000_0100 while WAIT, resp 4 cycles later -> resp dropped; next req addr 0x8000_0100, its data delivered.
//   HOLD with inst_ready=1 and redirect 0x8000_0040 together -> next req addr 0x8000_0040, not +4.
//   Redirect to 0xFFFF_FFFC, consume -> next req addr 0x0000_0000.
//   With IFU_MISALIGN_TRAP_EN: redirect 0x8000_0002 -> no imem request; fetch_fault=1, inst_pc=0x8000_0002.
//   Without IFU_MISALIGN_TRAP_EN: same redirect -> req addr 0x8000_0000.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction fetch bundle: imem request/response channel, core instruction channel and redirect.
// master = fetch unit side, slave = memory/core side.
interface inst_fetch_if #(
    parameter int XLEN = 32
);
    // Handshake rule for both *_valid/*_ready pairs: a transfer happens on a rising edge where
    // valid and ready are both 1; once valid is raised the payload stays stable until it transfers
    // (the only exception is a redirect, which may replace imem_req_addr). imem_resp_valid and
    // redirect_valid are one-cycle strobes without a ready.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request, instruction hand-off to the core, PC redirect.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_TRAP_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] inst_q, inst_n;
    logic [XLEN-1:0] inst_pc_q, inst_pc_n;
    logic [XLEN-1:0] target;
    logic            drop, drop_n;
    logic            fault, fault_n;
    logic            misaligned;

`ifdef IFU_MISALIGN_TRAP_EN
    assign target     = bus.redirect_pc;
    assign misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign target          = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign misaligned      = 1'b0;
    assign unused_low_bits = ^bus.redirect_pc[1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            inst_q    <= inst_n;
            inst_pc_q <= inst_pc_n;
            fault     <= fault_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        drop_n    = drop;
        inst_n    = inst_q;
        inst_pc_n = inst_pc_q;
        fault_n   = fault;

        // A squashed fetch may still answer after a trap took us to HOLD; it consumes the drop.
        if (drop && bus.imem_resp_valid && (state != WAIT)) drop_n = 1'b0;

        case (state)
            IDLE: begin
                state_n = REQ;
                if (bus.redirect_valid) pc_n = target;
            end
            REQ: begin
                if (bus.imem_req_ready) state_n = WAIT;
                if (bus.redirect_valid) begin
                    pc_n   = target;
                    drop_n = drop_n || bus.imem_req_ready;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (bus.redirect_valid) begin
                        pc_n    = target;
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        inst_n    = bus.imem_resp_data;
                        inst_pc_n = pc;
                        state_n   = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    pc_n   = target;
                    drop_n = 1'b1;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_n    = target;
                    fault_n = 1'b0;
                    state_n = REQ;
                end else if (bus.inst_ready) begin
                    pc_n    = pc + XLEN'(4);
                    fault_n = 1'b0;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase

        // Misaligned target: present a faulting slot to the core instead of fetching.
        if (misaligned) begin
            state_n   = HOLD;
            fault_n   = 1'b1;
            inst_n    = '0;
            inst_pc_n = bus.redirect_pc;
        end
    end

    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_fault    = fault;
    assign dbg_state          = state;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: latency, stall, redirect in every state, wrap, misalign, reset mid-fetch.
// Imem model answers a programmable number of cycles after each accepted request.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  dbg_state;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          mem_delay = 1;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        redir;
        logic [31:0] target;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[7];

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- imem model ----------------
    initial begin : imem_model
        logic        acc;
        logic        pend;
        logic [31:0] acc_addr;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        cnt  = 0;
        paddr = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            acc      = bus.imem_req_valid && bus.imem_req_ready;
            acc_addr = bus.imem_req_addr;
            #1;
            bus.imem_resp_valid = 1'b0;
            if (acc) begin
                pend  = 1'b1;
                cnt   = mem_delay;
                paddr = acc_addr;
            end
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(paddr);
                    pend = 1'b0;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_inst();
        logic [31:0] e;
        for (int i = 0; i < 30 && !bus.inst_valid; i++) @(negedge clk);
        check("inst_valid", 32'(bus.inst_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("inst_pc", bus.inst_pc, e);
            check("inst", bus.inst, mem_word(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
        check({tag, "_inst"}, bus.inst, 32'd0);
        check({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
        check({tag, "_fault"}, 32'(bus.fetch_fault), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_pc;

        vecs[0] = '{1'b0, 32'h0,         32'h8000_0008};
        vecs[1] = '{1'b1, 32'h8000_0040, 32'h8000_0040};
        vecs[2] = '{1'b0, 32'h0,         32'h8000_0044};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[4] = '{1'b0, 32'h0,         32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_1230, 32'h0000_1230};
        vecs[6] = '{1'b0, 32'h0,         32'h0000_1234};

        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // first fetch: request after 1 cycle, instruction on cycle 3
        @(negedge clk);
        check("c1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("c1_req_addr", bus.imem_req_addr, 32'h8000_0000);
        check("c1_inst_valid", 32'(bus.inst_valid), 32'd0);
        @(negedge clk);
        check("c2_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("c2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        check("c3_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("c3_inst_pc", bus.inst_pc, 32'h8000_0000);
        check("c3_inst", bus.inst, mem_word(32'h8000_0000));

        // core stalls for 5 cycles: slot held, nothing requested
        held_inst = bus.inst;
        held_pc   = bus.inst_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
            check("stall_inst", bus.inst, held_inst);
            check("stall_inst_pc", bus.inst_pc, held_pc);
            check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        end
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check("seq_req_addr", bus.imem_req_addr, 32'h8000_0004);
        exp_q.push_back(32'h8000_0004);
        wait_inst();

        // table: consume (optionally with a redirect) and check the next fetch
        foreach (vecs[k]) begin
            bus.inst_ready     = 1'b1;
            bus.redirect_valid = vecs[k].redir;
            bus.redirect_pc    = vecs[k].target;
            @(negedge clk);
            bus.inst_ready     = 1'b0;
            bus.redirect_valid = 1'b0;
            check("tbl_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check("tbl_req_addr", bus.imem_req_addr, vecs[k].exp_addr);
            exp_q.push_back(vecs[k].exp_addr);
            wait_inst();
        end

        // redirect while waiting on a slow response: stale data must be dropped
        mem_delay      = 4;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        @(negedge clk);
        check("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        mem_delay          = 1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.imem_req_valid; i++) begin
            check("drop_no_inst", 32'(bus.inst_valid), 32'd0);
            @(negedge clk);
        end
        check("drop_req_addr", bus.imem_req_addr, 32'h8000_0100);
        exp_q.push_back(32'h8000_0100);
        wait_inst();

        // request not accepted: address stable, then replaced by a redirect
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check("stuck_req_addr0", bus.imem_req_addr, 32'h8000_0104);
        @(negedge clk);
        check("stuck_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("stuck_req_addr1", bus.imem_req_addr, 32'h8000_0104);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0300;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("req_redirect_addr", bus.imem_req_addr, 32'h8000_0300);
        bus.imem_req_ready = 1'b1;
        exp_q.push_back(32'h8000_0300);
        wait_inst();

        // misaligned redirect from HOLD
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0002;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        check("mis_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("mis_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("mis_fault", 32'(bus.fetch_fault), 32'd1);
        check("mis_inst_pc", bus.inst_pc, 32'h8000_0002);
        check("mis_inst", bus.inst, 32'h0);
        @(negedge clk);
        check("mis_req_valid2", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0400;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("mis_clear_fault", 32'(bus.fetch_fault), 32'd0);
        check("mis_clear_addr", bus.imem_req_addr, 32'h8000_0400);
        exp_q.push_back(32'h8000_0400);
`else
        check("mis_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("mis_req_addr", bus.imem_req_addr, 32'h8000_0000);
        check("mis_fault", 32'(bus.fetch_fault), 32'd0);
        exp_q.push_back(32'h8000_0000);
`endif
        wait_inst();

        // reset while a fetch is in flight; the late response must be ignored
        mem_delay      = 3;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_delay = 1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10 && !bus.imem_req_valid; i++) @(negedge clk);
        check("post_reset_req_addr", bus.imem_req_addr, 32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        wait_inst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
